// File: rtl/axi_rd_master.sv
// AXI read master: turns a single user read request into one AR burst and
// streams the returned R beats back to the user one cycle after each handshake.
// Optional build macro AXI_RD_BEAT_CHECK_EN: the burst length is set by the beat
// counter, and any beat where axi_rlast disagrees with the count pulses rd_err.
// With the macro undefined, the burst ends on axi_rlast and rd_err stays 0.
//
// state | meaning
// IDLE  | waiting for an accepted rd_trig (rd_ready = init_end)
// AR    | address phase, arvalid held until arready
// RD    | accepting R beats, rready high
// DONE  | one cycle, final beat and rd_done presented
module axi_rd_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int RBURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_end,
  input  logic                  rd_trig,
  input  logic [7:0]            rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_en,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic                  axi_rlast,
  input  logic [DATA_WIDTH-1:0] axi_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            arlen_q;
  logic [7:0]            cnt;
  logic                  accept;
  logic                  r_hs;
  logic                  beat_last;
  logic                  beat_err;

  // rstn gates rd_ready so it reads 0 while reset is held, even with init_end high
  assign rd_ready    = rstn && (state == IDLE) && init_end;
  assign accept      = rd_trig && rd_ready && (rd_len != 8'd0) &&
                       (rd_len <= 8'(RBURST_LEN));
  assign axi_arvalid = (state == AR);
  assign axi_araddr  = addr_q;
  assign axi_arlen   = arlen_q;
  assign axi_rready  = (state == RD);
  assign r_hs        = axi_rvalid && axi_rready;

`ifdef AXI_RD_BEAT_CHECK_EN
  // cnt still holds the previous beat count, so the final beat is cnt == len-1
  assign beat_last = (cnt == arlen_q);
  assign beat_err  = (axi_rlast != beat_last);
`else
  assign beat_last = axi_rlast;
  assign beat_err  = 1'b0;
`endif

  // Sequencing FSM with request latch and beat counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      addr_q  <= '0;
      arlen_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q  <= rd_addr;
          arlen_q <= rd_len - 8'd1;
          state   <= AR;
        end
        AR: if (axi_arready) begin
          cnt   <= '0;
          state <= RD;
        end
        RD: if (r_hs) begin
          cnt <= cnt + 8'd1;
          if (beat_last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered user-side beat outputs, one cycle after each R handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data    <= '0;
      rd_data_en <= 1'b0;
      rd_done    <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      rd_data_en <= r_hs;
      rd_done    <= r_hs && beat_last;
      rd_err     <= r_hs && beat_err;
      if (r_hs) rd_data <= axi_rdata;
    end
  end

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master with an inline AXI slave model.
module tb_axi_rd_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        init_end;
  logic        rd_trig;
  logic [7:0]  rd_len;
  logic [26:0] rd_addr;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_data_en;
  logic        rd_done;
  logic        rd_err;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [26:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        axi_rlast;
  logic [15:0] axi_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_rd_master dut (
    .clk(clk), .rstn(rstn), .init_end(init_end), .rd_trig(rd_trig),
    .rd_len(rd_len), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_en(rd_data_en), .rd_done(rd_done),
    .rd_err(rd_err), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_rlast(axi_rlast), .axi_rdata(axi_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {7'd0, rd_ready, rd_data, rd_data_en, rd_done, rd_err,
            axi_arvalid, axi_araddr, axi_arlen, axi_rready};
  endfunction

  // One request end to end; slave asserts rlast on last_beat; abort>0 returns
  // right after that beat's rd_data_en is seen.
  task automatic do_burst(input int len, input logic [26:0] addr, input int ar_delay,
                          input int gap, input int last_beat, input int abort);
    int beat, k, en_cnt, done_beat;
    bit hs, seen_done, exp_err;
`ifdef AXI_RD_BEAT_CHECK_EN
    done_beat = len;
`else
    done_beat = last_beat;
`endif
    chk("ready_before_trig", rd_ready, 1);
    rd_trig = 1; rd_len = 8'(len); rd_addr = addr;
    tick();
    rd_trig = 0; rd_addr = '0; rd_len = 8'd0;
    chk("arvalid_set", axi_arvalid, 1);
    chk("ready_low_in_ar", rd_ready, 0);
    chk("araddr", axi_araddr, addr);
    chk("arlen", axi_arlen, len - 1);
    for (int i = 0; i < ar_delay; i++) begin
      tick();
      chk("ar_hold", {axi_arvalid, axi_araddr, axi_arlen}, {1'b1, addr, 8'(len - 1)});
    end
    axi_arready = 1;
    tick();
    axi_arready = 0;
    chk("ar_dropped", axi_arvalid, 0);
    beat = 1; k = 0; en_cnt = 0; seen_done = 0;
    while (!seen_done && k < 200) begin
      chk("rready_in_rd", axi_rready, 1);
      hs = ((k % (gap + 1)) == 0);
      axi_rvalid = hs;
      axi_rdata  = hs ? 16'(beat) : 16'hdead;
      axi_rlast  = hs && (beat == last_beat);
      tick();
      k++;
      if (hs) begin
        exp_err = 0;
`ifdef AXI_RD_BEAT_CHECK_EN
        exp_err = ((beat == last_beat) != (beat == len));
`endif
        chk("data_en", rd_data_en, 1);
        chk("data", rd_data, beat);
        chk("done", rd_done, beat == done_beat);
        chk("err", rd_err, exp_err);
        en_cnt++;
        seen_done = (beat == done_beat);
        if (beat == abort) begin
          axi_rvalid = 0; axi_rlast = 0;
          return;
        end
        beat++;
      end else begin
        chk("gap_no_en", {rd_data_en, rd_done}, 0);
        if (beat > 1) chk("gap_data_hold", rd_data, beat - 1);
      end
    end
    axi_rvalid = 0; axi_rlast = 0;
    chk("burst_finished", seen_done, 1);
    chk("beat_count", en_cnt, done_beat);
    chk("rready_low_in_done", axi_rready, 0);
    tick();
    chk("post_done_quiet", {rd_data_en, rd_done, rd_err, axi_arvalid, axi_rready}, 0);
    chk("post_done_data_hold", rd_data, done_beat);
    chk("ready_back_to_back", rd_ready, 1);
  endtask

  initial begin
    bit bad;
    rstn = 0; init_end = 0; rd_trig = 0; rd_len = 0; rd_addr = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0;
    #12;
    chk("reset_outputs", all_outs(), 0);
    tick();
    rstn = 1;
    tick();

    // init_end low: trigger must be ignored for 20 cycles
    rd_trig = 1; rd_len = 8'd8; rd_addr = 27'h10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_ready !== 1'b0 || axi_arvalid !== 1'b0) bad = 1;
    end
    chk("no_init_ignored", bad, 0);
    rd_trig = 0;

    init_end = 1;
    #1;
    chk("ready_follows_init", rd_ready, 1);

    // Illegal lengths 0 and 9
    rd_len = 8'd0; rd_trig = 1; rd_addr = 27'h20;
    tick();
    rd_trig = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (axi_arvalid !== 1'b0 || rd_ready !== 1'b1) bad = 1;
    end
    chk("len0_ignored", bad, 0);
    rd_len = 8'd9; rd_trig = 1;
    tick();
    rd_trig = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (axi_arvalid !== 1'b0 || rd_ready !== 1'b1) bad = 1;
    end
    chk("len9_ignored", bad, 0);

    // Main 8-beat burst, arready after 3 cycles
    do_burst(8, 27'h10, 3, 0, 8, 0);
    // Back-to-back single beat, then gapped burst
    do_burst(1, 27'h7ffffff, 0, 0, 1, 0);
    do_burst(8, 27'h40, 1, 2, 8, 0);
    // Early rlast on beat 6
    do_burst(8, 27'h80, 0, 0, 6, 0);

    // Reset asserted during beat 4
    do_burst(8, 27'h100, 0, 0, 8, 4);
    #2;
    rstn = 0;
    #1;
    chk("mid_reset_outputs", all_outs(), 0);
    tick();
    chk("reset_held_outputs", all_outs(), 0);
    rstn = 1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (axi_arvalid !== 1'b0) bad = 1;
    end
    chk("no_ar_after_reset", bad, 0);
    do_burst(4, 27'h200, 1, 0, 4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_master.md
AXI_RD_MASTER -- requirements
Module: axi_rd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, the AXI/user address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the AXI/user data width.
REQ-003 SHALL have parameter RBURST_LEN, default 8, the maximum accepted rd_len.
REQ-004 SHALL have port clk  in  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port init_end  in  1  DDR2 initialisation complete.
REQ-007 SHALL have port rd_trig  in  1  user read request.
REQ-008 SHALL have port rd_len  in  8  beats requested.
REQ-009 SHALL have port rd_addr  in  ADDR_WIDTH  start address.
REQ-010 SHALL have port rd_ready  out  1  ready to accept rd_trig.
REQ-011 SHALL have port rd_data  out  DATA_WIDTH  returned beat.
REQ-012 SHALL have port rd_data_en  out  1  rd_data valid strobe.
REQ-013 SHALL have port rd_done  out  1  burst complete pulse.
REQ-014 SHALL have port rd_err  out  1  beat-count mismatch pulse.
REQ-015 SHALL have port axi_arvalid, axi_arready, axi_araddr[ADDR_WIDTH], axi_arlen[8] as AR-channel master.
REQ-016 SHALL have port axi_rvalid, axi_rready, axi_rlast, axi_rdata[DATA_WIDTH] as R-channel master.

Function
REQ-017 SHALL implement states IDLE, AR, RD, DONE.
REQ-018 IDLE: rd_ready = init_end; rd_trig && rd_ready with 1 <= rd_len <= RBURST_LEN latches rd_addr and rd_len and moves to AR next cycle.
REQ-019 SHALL ignore rd_trig when init_end is 0, when rd_len is 0, or when rd_len > RBURST_LEN (remain IDLE, no AR issued).
REQ-020 rd_ready SHALL be 0 in AR, RD, DONE.
REQ-021 AR: axi_arvalid=1, axi_araddr=latched address, axi_arlen=latched rd_len-1; both held stable until axi_arready; on handshake go to RD.
REQ-022 RD: axi_rready=1 continuously; axi_rready=0 in all other states.
REQ-023 Each R handshake (rvalid && rready) SHALL register axi_rdata into rd_data and pulse rd_data_en for exactly one cycle, one cycle after the handshake.
REQ-024 SHALL keep an 8-bit beat counter, cleared on AR handshake, incremented per R handshake.
REQ-025 rd_data SHALL hold its last value when rd_data_en is 0.
REQ-026 DONE: single cycle; rd_done=1 coincident with the final rd_data_en; then IDLE.
REQ-027 Latency: rd_trig accepted at cycle N -> arvalid at N+1 at the earliest; first rd_data_en one cycle after the first R handshake.
REQ-028 SHALL accept back-to-back requests: rd_ready reasserts the cycle after DONE.

Reset
REQ-029 rstn low SHALL asynchronously force IDLE, counter 0, latched address/length 0, and all outputs 0 (rd_data 0), including mid-burst.
REQ-030 After rstn releases, no AR SHALL be issued until a new accepted rd_trig.

Configuration
REQ-031 Macro AXI_RD_BEAT_CHECK_EN: when defined, burst ends on the beat reaching latched rd_len; if axi_rlast disagrees with the count on any beat, rd_err pulses one cycle with that beat's rd_data_en.
REQ-032 Without AXI_RD_BEAT_CHECK_EN: burst ends on axi_rlast alone; the counter is still maintained; rd_err is tied 0.

Verification
REQ-033 init_end=0, rd_trig=1 for 20 cycles -> rd_ready=0, axi_arvalid never 1.
REQ-034 init_end=1, rd_trig with rd_len=8, rd_addr=0x10, arready after 3 cycles -> araddr=0x10, arlen=7 stable until handshake; 8 rd_data_en pulses carrying 1..8; rd_done with the 8th.
REQ-035 rd_len=0 and rd_len=9 -> no AR, rd_ready stays 1.
REQ-036 Gapped rvalid (1 on, 2 off) for an 8-beat burst -> exactly 8 rd_data_en pulses, data in order, rd_done once.
REQ-037 With AXI_RD_BEAT_CHECK_EN, rd_len=8, axi_rlast on beat 6 -> rd_err pulses at beat 6; rd_done after beat 8; without the macro -> rd_done at beat 6, rd_err=0.
REQ-038 rstn low during beat 4 -> all outputs 0 immediately; after release, a new rd_len=4 request completes normally.
